// File: rtl/filter_sequencer.sv
// Purpose: per-frame strobe sequencer for the filter datapath; runs CLEAR/SETTLE/RUN on filter changes.
// Latency: every output is registered; a filter_req change sampled at frame end appears on the next phase 0.
// Backpressure: none; the phase counter free-runs every cycle and cannot be stalled.
//
// Ports:
//   clk_144     in   single clock, rising edge
//   reset       in   synchronous, active-high
//   filter_req  in   [2:0] requested filter, sampled only at frame end
//   frame_start out  strobe in phase 0 of every frame
//   hp_en       out  highpass enable, phase 0 (suppressed in CLEAR)
//   lp_en       out  lowpass enable, phase 1 (suppressed in CLEAR)
//   out_load    out  output register load, last phase of every frame
//   filter_sel  out  [2:0] filter currently applied to the datapath
//   state_clr   out  clears filter delay lines for the whole CLEAR frame
//   mute        out  forces downstream output to zero in CLEAR and SETTLE
//   settling    out  high whenever the sequencer is not in RUN
module filter_sequencer #(
    parameter int FRAME_CYCLES  = 3,
    parameter int SETTLE_FRAMES = 16
) (
    input  logic       clk_144,
    input  logic       reset,
    input  logic [2:0] filter_req,
    output logic       frame_start,
    output logic       hp_en,
    output logic       lp_en,
    output logic       out_load,
    output logic [2:0] filter_sel,
    output logic       state_clr,
    output logic       mute,
    output logic       settling
);

    localparam int PW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int CW = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
    localparam logic [PW-1:0] LAST_PH     = PW'(FRAME_CYCLES - 1);
    localparam logic [PW-1:0] LP_PH       = PW'(1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_FRAMES - 1);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   phase;
    logic [PW-1:0]   phase_nxt;
    logic [CW-1:0]   settle_cnt;
    logic [CW-1:0]   settle_cnt_nxt;
    logic [2:0]      sel_nxt;
    logic            frame_end;
    // Low for the first cycle out of reset so that cycle is forced to phase 0
    // without running a frame-end evaluation.
    logic            armed;

    // State register
    always_ff @(posedge clk_144) begin
        if (reset) begin
            state      <= CLEAR;
            settle_cnt <= '0;
            phase      <= '0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            phase      <= phase_nxt;
            armed      <= 1'b1;
        end
    end

    // Next-state logic: phase advance and the frame-end rules in priority order
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        sel_nxt        = filter_sel;
        phase_nxt      = phase;
        frame_end      = armed && (phase == LAST_PH);

        if (!armed || frame_end) begin
            phase_nxt = '0;
        end else begin
            phase_nxt = phase + PW'(1);
        end

        if (frame_end) begin
            if (filter_req != filter_sel) begin
                sel_nxt        = filter_req;
                state_nxt      = CLEAR;
                settle_cnt_nxt = '0;
            end else begin
                case (state)
                    CLEAR: begin
                        state_nxt      = SETTLE;
                        settle_cnt_nxt = '0;
                    end
                    SETTLE: begin
                        // Count stops at SETTLE_LAST, so it can never wrap.
                        if (settle_cnt == SETTLE_LAST) begin
                            state_nxt = RUN;
                        end else begin
                            settle_cnt_nxt = settle_cnt + CW'(1);
                        end
                    end
                    default: state_nxt = RUN;
                endcase
            end
        end
    end

    // Outputs are decoded from the next-cycle phase/state and registered, so
    // each output lines up with the cycle it describes and filter_req only
    // reaches outputs through a flop.
    always_ff @(posedge clk_144) begin
        if (reset) begin
            frame_start <= 1'b0;
            hp_en       <= 1'b0;
            lp_en       <= 1'b0;
            out_load    <= 1'b0;
            filter_sel  <= 3'd0;
            state_clr   <= 1'b1;
            mute        <= 1'b1;
            settling    <= 1'b1;
        end else begin
            frame_start <= (phase_nxt == '0);
            hp_en       <= (phase_nxt == '0) && (state_nxt != CLEAR);
            lp_en       <= (phase_nxt == LP_PH) && (state_nxt != CLEAR);
            out_load    <= (phase_nxt == LAST_PH);
            filter_sel  <= sel_nxt;
            state_clr   <= (state_nxt == CLEAR);
            mute        <= (state_nxt != RUN);
            settling    <= (state_nxt != RUN);
        end
    end

endmodule

// File: tb/tb_filter_sequencer.sv
// Purpose: directed self-checking bench for filter_sequencer.
// Latency: checks each cycle #1 after the rising edge against a small per-phase model.
// Backpressure: not applicable; stimulus is a linear directed sequence.
module tb_filter_sequencer;

    localparam int FC  = 3;
    localparam int SF  = 16;
    localparam int CLR = 0;
    localparam int SET = 1;
    localparam int RN  = 2;

    logic       clk_144 = 1'b0;
    logic       reset;
    logic [2:0] filter_req;
    logic       frame_start, hp_en, lp_en, out_load;
    logic [2:0] filter_sel;
    logic       state_clr, mute, settling;
    logic [31:0] obs;

    int errors = 0;
    int checks = 0;

    filter_sequencer #(
        .FRAME_CYCLES (FC),
        .SETTLE_FRAMES(SF)
    ) dut (
        .clk_144    (clk_144),
        .reset      (reset),
        .filter_req (filter_req),
        .frame_start(frame_start),
        .hp_en      (hp_en),
        .lp_en      (lp_en),
        .out_load   (out_load),
        .filter_sel (filter_sel),
        .state_clr  (state_clr),
        .mute       (mute),
        .settling   (settling)
    );

    always #5 clk_144 = ~clk_144;

    assign obs = {22'd0, frame_start, hp_en, lp_en, out_load, state_clr, mute, settling, filter_sel};

    function automatic logic [31:0] exp_vec(input int ph, input int st, input logic [2:0] sel);
        return {22'd0, (ph == 0), (ph == 0) && (st != CLR), (ph == 1) && (st != CLR),
                (ph == FC - 1), (st == CLR), (st != RN), (st != RN), sel};
    endfunction

    localparam logic [31:0] RESET_VEC = {22'd0, 4'b0000, 3'b111, 3'd0};

    task automatic tick();
        @(posedge clk_144);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input int ph, input int st, input logic [2:0] sel);
        tick();
        check(tag, obs, exp_vec(ph, st, sel));
    endtask

    // Full restart schedule from a phase-0 CLEAR frame: one CLEAR frame,
    // SF SETTLE frames, then RUN.
    task automatic run_seq(input string tag, input logic [2:0] sel, input int n);
        for (int c = 0; c < n; c++) begin
            int st;
            st = (c < FC) ? CLR : (c < FC * (SF + 1)) ? SET : RN;
            step(tag, c % FC, st, sel);
        end
    endtask

    initial begin
        logic fs_d1;
        logic fs_d2;
        int   gap;
        int   nfs;

        reset      = 1'b1;
        filter_req = 3'd0;

        // Reset values
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", obs, RESET_VEC);
        end

        // Startup: CLEAR cycles 0-2, SETTLE 3-50, RUN from 51
        reset = 1'b0;
        run_seq("startup", 3'd0, 60);

        // Steady RUN strobe relationships
        fs_d1 = 1'b0;
        fs_d2 = 1'b0;
        gap   = 2;
        nfs   = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            gap++;
            check("run_strobes", {27'd0, hp_en, lp_en, out_load, state_clr, mute},
                  {27'd0, frame_start, fs_d1, fs_d2, 1'b0, 1'b0});
            if (frame_start) begin
                check("run_frame_gap", 32'(gap), 32'(FC));
                nfs++;
                gap = 0;
            end
            fs_d2 = fs_d1;
            fs_d1 = frame_start;
        end
        check("run_frame_count", 32'(nfs), 32'(3000 / FC));

        // Short glitch on filter_req, reverted before frame end: no effect
        step("glitch", 0, RN, 3'd0);
        filter_req = 3'd5;
        step("glitch", 1, RN, 3'd0);
        step("glitch", 2, RN, 3'd0);
        filter_req = 3'd0;
        step("glitch", 0, RN, 3'd0);
        step("glitch", 1, RN, 3'd0);
        step("glitch", 2, RN, 3'd0);

        // Change 0 -> 2 at phase 1 of a RUN frame
        step("chg_run", 0, RN, 3'd0);
        step("chg_run", 1, RN, 3'd0);
        filter_req = 3'd2;
        step("chg_run", 2, RN, 3'd0);
        run_seq("chg_run_seq", 3'd2, 60);

        // Change during CLEAR re-clears with the newer value
        step("reclear", 0, RN, 3'd2);
        filter_req = 3'd6;
        step("reclear", 1, RN, 3'd2);
        step("reclear", 2, RN, 3'd2);
        step("reclear", 0, CLR, 3'd6);
        filter_req = 3'd2;
        step("reclear", 1, CLR, 3'd6);
        step("reclear", 2, CLR, 3'd6);

        // Change 2 -> 4 during the 5th SETTLE frame restarts the full sequence
        run_seq("pre_settle", 3'd2, 16);
        filter_req = 3'd4;
        step("chg_settle", 1, SET, 3'd2);
        step("chg_settle", 2, SET, 3'd2);
        run_seq("chg_settle_seq", 3'd4, 60);

        // Reset for 2 cycles starting at phase 1 of a SETTLE frame
        filter_req = 3'd0;
        run_seq("pre_reset", 3'd0, 5);
        reset = 1'b1;
        tick();
        check("mid_reset", obs, RESET_VEC);
        tick();
        check("mid_reset", obs, RESET_VEC);
        reset = 1'b0;
        run_seq("restart", 3'd0, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filter_sequencer.md
FILTER_SEQUENCER -- requirements
Module: filter_sequencer

Interface
REQ-001 The block SHALL have parameter FRAME_CYCLES, default 3, giving clk_144 cycles per audio sample frame (3 x 48 kHz); legal range is 3 or more.
REQ-002 The block SHALL have parameter SETTLE_FRAMES, default 16, giving the number of muted frames after a state clear; legal range is 1 or more.
REQ-003 The block SHALL have port clk_144, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port filter_req, input, 3 bits: requested filter selection from the user controls.
REQ-006 The block SHALL have port frame_start, output, 1 bit: one-cycle strobe marking phase 0 of each frame.
REQ-007 The block SHALL have port hp_en, output, 1 bit: highpass stage compute enable.
REQ-008 The block SHALL have port lp_en, output, 1 bit: lowpass stage compute enable.
REQ-009 The block SHALL have port out_load, output, 1 bit: output register load strobe.
REQ-010 The block SHALL have port filter_sel, output, 3 bits: the filter selection currently applied to the datapath.
REQ-011 The block SHALL have port state_clr, output, 1 bit: clears the filter delay-line state.
REQ-012 The block SHALL have port mute, output, 1 bit: forces the downstream output to zero.
REQ-013 The block SHALL have port settling, output, 1 bit: high whenever the state is not RUN.

Function
REQ-014 The block SHALL run a phase counter 0..FRAME_CYCLES-1 that advances every cycle and wraps from FRAME_CYCLES-1 to 0; there is no stall input.
REQ-015 All outputs SHALL be registered, with no combinational path from filter_req to any output.
REQ-016 frame_start SHALL be 1 exactly in phase-0 cycles, in every state.
REQ-017 hp_en SHALL be 1 in phase 0 and lp_en SHALL be 1 in phase 1; both are forced to 0 in state CLEAR.
REQ-018 out_load SHALL be 1 in phase FRAME_CYCLES-1, in every state.
REQ-019 The FSM states SHALL be CLEAR, SETTLE and RUN; the state and filter_sel change only at frame boundaries and are constant within a frame.
REQ-020 At each frame end (the edge closing phase FRAME_CYCLES-1), the FSM SHALL evaluate the following rules in priority order:
  a) In any state, if filter_req differs from filter_sel: filter_sel takes filter_req, the next state is CLEAR, and the settle count is zeroed.
  b) Otherwise, CLEAR goes to SETTLE with the settle count at 0.
  c) Otherwise, SETTLE goes to RUN when the settle count equals SETTLE_FRAMES-1; otherwise the settle count increments.
  d) Otherwise, RUN stays in RUN.
REQ-021 filter_req SHALL be sampled only at frame end, so a value held for less than a frame that has reverted by the frame end has no effect.
REQ-022 state_clr SHALL be 1 for the whole of every CLEAR frame and 0 otherwise.
REQ-023 mute SHALL be 1 in CLEAR and SETTLE and 0 in RUN.
REQ-024 A filter change that occurs during SETTLE SHALL restart the full sequence: one CLEAR frame followed by SETTLE_FRAMES SETTLE frames.
REQ-025 The settle counter SHALL be ceil(log2(SETTLE_FRAMES+1)) bits wide and SHALL never wrap.

Reset
REQ-026 While reset is sampled high, the block SHALL hold: frame_start, hp_en, lp_en and out_load at 0; filter_sel at 0; state_clr, mute and settling at 1; state CLEAR; settle count 0.
REQ-027 The cycle following the first edge with reset low SHALL be phase 0 of frame 0, in state CLEAR.
REQ-028 Reset asserted mid-frame or in any state SHALL abandon the frame immediately; no partial strobes follow.

Verification
REQ-029 Reset release with filter_req=0 (cycle 0 = phase 0 of frame 0) SHALL produce:
  - state_clr=1 in cycles 0-2, with hp_en and lp_en at 0;
  - SETTLE from cycle 3 through cycle 50, with mute=1 and hp_en pulses at 3, 6, 9 and so on;
  - from cycle 51, mute=0 and settling=0.
REQ-030 In steady RUN over 3000 cycles, the bench SHALL check that per frame there is exactly one frame_start, and that:
  - hp_en is coincident with frame_start;
  - lp_en follows frame_start by 1 cycle;
  - out_load follows frame_start by 2 cycles.
REQ-031 In RUN, filter_req changing 0 to 2 at phase 1 SHALL leave filter_sel=0 until the next phase 0, then give filter_sel=2, a 3-cycle CLEAR, and 48 cycles of mute before RUN.
REQ-032 A filter_req change 2 to 4 during the 5th SETTLE frame SHALL give CLEAR at the next frame, then a full 16 SETTLE frames, with filter_sel=4.
REQ-033 filter_req=5 during phases 0-1 only, back to 0 by phase 2, SHALL give no state change and filter_sel stays 0.
REQ-034 Reset held for 2 cycles starting at phase 1 of a SETTLE frame SHALL give all strobes 0 during reset and filter_sel=0, and the sequence of REQ-029 SHALL then restart.
